key_mode_ctrl: RTL and testbench

- Front-end control stage directly upstream of the display top level. Consumes the raw active-low push-buttons (i_key_n[1:0]) and turns them into a scaling-mode selection for the nearest-neighbour scaler and HDMI path.
- Synchronises and debounces each key, then emits press, release and long-press pulses.
- Keeps a wrap-around mode register that the scaler samples.
- Runs entirely in the core_clk domain.

---
 rtl/key_mode_ctrl.sv | 135 +++++++++++++
 tb/tb_key_mode_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/key_mode_ctrl.sv
// Debounced push-button front end: sync + per-key press/release/long FSM feeding a wrap-around scaler mode register.
// Press/release visible 2+DEBOUNCE_CYCLES edges after a clean key edge, mode one cycle later; no backpressure, pulses are fire-and-forget.
module key_mode_ctrl #(
  parameter int unsigned KEY_NUM           = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 4_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 200_000_000,
  parameter int unsigned MODE_NUM          = 4,
  parameter int unsigned DEFAULT_MODE      = 0
) (
  input  logic                        core_clk,
  input  logic                        rst_n,
  input  logic [KEY_NUM-1:0]          i_key_n,
  output logic [KEY_NUM-1:0]          o_key_state,
  output logic [KEY_NUM-1:0]          o_key_press,
  output logic [KEY_NUM-1:0]          o_key_release,
  output logic [KEY_NUM-1:0]          o_key_long,
  output logic [$clog2(MODE_NUM)-1:0] o_mode,
  output logic                        o_mode_update
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int LP_W   = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam int MODE_W = $clog2(MODE_NUM);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LP_W-1:0]   LP_LAST   = LP_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LP_W-1:0]   LP_MAX    = LP_W'(LONG_PRESS_CYCLES);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(MODE_NUM - 1);
  localparam logic [MODE_W-1:0] MODE_DEF  = MODE_W'(DEFAULT_MODE);

  typedef enum logic {
    RELEASED = 1'b0,
    HELD     = 1'b1
  } key_fsm_e;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    logic [1:0]      sync_q;
    key_fsm_e        st_q;
    logic [DB_W-1:0] db_cnt;
    logic [LP_W-1:0] hold_cnt;
    logic            state_r;
    logic            press_r;
    logic            release_r;
    logic            long_r;
    logic            key_s;

    assign key_s = sync_q[1];

    always_ff @(posedge core_clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q    <= 2'b11;
        st_q      <= RELEASED;
        db_cnt    <= '0;
        hold_cnt  <= '0;
        state_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
      end else begin
        sync_q    <= {sync_q[0], i_key_n[g]};
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
        case (st_q)
          RELEASED: begin
            if (!key_s) begin
              if (db_cnt == DB_LAST) begin
                st_q     <= HELD;
                state_r  <= 1'b1;
                press_r  <= 1'b1;
                db_cnt   <= '0;
                hold_cnt <= '0;
              end else begin
                db_cnt <= db_cnt + DB_W'(1);
              end
            end else begin
              db_cnt <= '0;
            end
          end
          HELD: begin
            // Saturating at LONG_PRESS_CYCLES makes the LP_LAST match unique per press.
            if (hold_cnt != LP_MAX) begin
              hold_cnt <= hold_cnt + LP_W'(1);
            end
            if (hold_cnt == LP_LAST) begin
              long_r <= 1'b1;
            end
            if (key_s) begin
              if (db_cnt == DB_LAST) begin
                st_q      <= RELEASED;
                state_r   <= 1'b0;
                release_r <= 1'b1;
                db_cnt    <= '0;
              end else begin
                db_cnt <= db_cnt + DB_W'(1);
              end
            end else begin
              db_cnt <= '0;
            end
          end
          default: begin
            st_q   <= RELEASED;
            db_cnt <= '0;
          end
        endcase
      end
    end

    assign o_key_state[g]   = state_r;
    assign o_key_press[g]   = press_r;
    assign o_key_release[g] = release_r;
    assign o_key_long[g]    = long_r;
  end

  // Only keys 0 (next) and 1 (prev) steer the mode; a same-cycle press on both restores the default.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mode        <= MODE_DEF;
      o_mode_update <= 1'b0;
    end else begin
      o_mode_update <= 1'b0;
      if (o_key_press[0] && o_key_press[1]) begin
        o_mode        <= MODE_DEF;
        o_mode_update <= 1'b1;
      end else if (o_key_press[0]) begin
        o_mode        <= (o_mode == MODE_LAST) ? '0 : o_mode + MODE_W'(1);
        o_mode_update <= 1'b1;
      end else if (o_key_press[1]) begin
        o_mode        <= (o_mode == '0) ? MODE_LAST : o_mode - MODE_W'(1);
        o_mode_update <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Directed bench for key_mode_ctrl with DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, MODE_NUM=4.
module tb_key_mode_ctrl;

  logic       core_clk = 1'b0;
  logic       rst_n    = 1'b0;
  logic [1:0] i_key_n  = 2'b11;
  logic [1:0] o_key_state, o_key_press, o_key_release, o_key_long;
  logic [1:0] o_mode;
  logic       o_mode_update;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  int press_n [2];
  int rel_n   [2];
  int long_n  [2];
  int press_at[2];
  int rel_at  [2];
  int long_at [2];
  int upd_n   = 0;
  int upd_at  = 0;

  key_mode_ctrl #(
    .KEY_NUM(2),
    .DEBOUNCE_CYCLES(8),
    .LONG_PRESS_CYCLES(32),
    .MODE_NUM(4),
    .DEFAULT_MODE(0)
  ) dut (
    .core_clk(core_clk),
    .rst_n(rst_n),
    .i_key_n(i_key_n),
    .o_key_state(o_key_state),
    .o_key_press(o_key_press),
    .o_key_release(o_key_release),
    .o_key_long(o_key_long),
    .o_mode(o_mode),
    .o_mode_update(o_mode_update)
  );

  always #5 core_clk = ~core_clk;

  always @(posedge core_clk) cyc <= cyc + 1;

  // Pulse recorder: cyc here equals the index of the posedge that produced the pulse.
  always @(negedge core_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (o_key_press[k])   begin press_n[k]++; press_at[k] = cyc; end
      if (o_key_release[k]) begin rel_n[k]++;   rel_at[k]   = cyc; end
      if (o_key_long[k])    begin long_n[k]++;  long_at[k]  = cyc; end
    end
    if (o_mode_update) begin upd_n++; upd_at = cyc; end
  end

  typedef struct {
    logic [1:0] key_n;
    int         len;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] lng;
    int         upd;
    logic [1:0] mode;
    logic [1:0] state;
  } seg_t;

  localparam int NSEG = 17;
  seg_t segs [NSEG];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive a level just after the next posedge, hold it n edges, return at mid-cycle after the monitor ran.
  task automatic hold(input logic [1:0] k, input int n, output int start);
    @(posedge core_clk);
    #1;
    i_key_n = k;
    start   = cyc;
    repeat (n) @(posedge core_clk);
    @(negedge core_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int t, r, p0, p1, r0, r1, l0, l1, u;

    segs[0]  = '{2'b11, 100, 2'b00, 2'b00, 2'b00, 0, 2'd0, 2'b00};
    segs[1]  = '{2'b10,  20, 2'b01, 2'b00, 2'b00, 1, 2'd1, 2'b01};
    segs[2]  = '{2'b11,  20, 2'b00, 2'b01, 2'b00, 0, 2'd1, 2'b00};
    segs[3]  = '{2'b10,  15, 2'b01, 2'b00, 2'b00, 1, 2'd2, 2'b01};
    segs[4]  = '{2'b11,  15, 2'b00, 2'b01, 2'b00, 0, 2'd2, 2'b00};
    segs[5]  = '{2'b10,  15, 2'b01, 2'b00, 2'b00, 1, 2'd3, 2'b01};
    segs[6]  = '{2'b11,  15, 2'b00, 2'b01, 2'b00, 0, 2'd3, 2'b00};
    segs[7]  = '{2'b10,  15, 2'b01, 2'b00, 2'b00, 1, 2'd0, 2'b01};
    segs[8]  = '{2'b11,  15, 2'b00, 2'b01, 2'b00, 0, 2'd0, 2'b00};
    segs[9]  = '{2'b01,  15, 2'b10, 2'b00, 2'b00, 1, 2'd3, 2'b10};
    segs[10] = '{2'b11,  15, 2'b00, 2'b10, 2'b00, 0, 2'd3, 2'b00};
    segs[11] = '{2'b01,  60, 2'b10, 2'b00, 2'b10, 1, 2'd2, 2'b10};
    segs[12] = '{2'b11,  15, 2'b00, 2'b10, 2'b00, 0, 2'd2, 2'b00};
    segs[13] = '{2'b00,  20, 2'b11, 2'b00, 2'b00, 1, 2'd0, 2'b11};
    segs[14] = '{2'b11,  20, 2'b00, 2'b11, 2'b00, 0, 2'd0, 2'b00};
    segs[15] = '{2'b00,  20, 2'b11, 2'b00, 2'b00, 1, 2'd0, 2'b11};
    segs[16] = '{2'b11,  20, 2'b00, 2'b11, 2'b00, 0, 2'd0, 2'b00};

    // Reset state
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    check("rst state",   int'(o_key_state),   0);
    check("rst press",   int'(o_key_press),   0);
    check("rst release", int'(o_key_release), 0);
    check("rst long",    int'(o_key_long),    0);
    check("rst mode",    int'(o_mode),        0);
    check("rst update",  int'(o_mode_update), 0);
    @(posedge core_clk);
    #1;
    rst_n = 1'b1;

    // Table: each segment holds a key level and checks the pulses it caused plus the settled outputs
    for (int i = 0; i < NSEG; i++) begin
      p0 = press_n[0]; p1 = press_n[1]; r0 = rel_n[0]; r1 = rel_n[1];
      l0 = long_n[0];  l1 = long_n[1];  u  = upd_n;
      hold(segs[i].key_n, segs[i].len, t);
      check($sformatf("seg%0d press0", i),   press_n[0] - p0, int'(segs[i].press[0]));
      check($sformatf("seg%0d press1", i),   press_n[1] - p1, int'(segs[i].press[1]));
      check($sformatf("seg%0d release0", i), rel_n[0] - r0,   int'(segs[i].rel[0]));
      check($sformatf("seg%0d release1", i), rel_n[1] - r1,   int'(segs[i].rel[1]));
      check($sformatf("seg%0d long0", i),    long_n[0] - l0,  int'(segs[i].lng[0]));
      check($sformatf("seg%0d long1", i),    long_n[1] - l1,  int'(segs[i].lng[1]));
      check($sformatf("seg%0d update", i),   upd_n - u,       segs[i].upd);
      check($sformatf("seg%0d mode", i),     int'(o_mode),    int'(segs[i].mode));
      check($sformatf("seg%0d state", i),    int'(o_key_state), int'(segs[i].state));
    end

    // Exact press / update / release latency on key0 (mode 0 -> 1)
    hold(2'b10, 20, t);
    check("lat press edge",  press_at[0], t + 10);
    check("lat update edge", upd_at,      t + 11);
    check("lat mode",        int'(o_mode), 1);
    hold(2'b11, 20, t);
    check("lat release edge", rel_at[0], t + 10);

    // Bounce: low 5 / high 2, ten times, must be ignored
    p0 = press_n[0]; u = upd_n;
    for (int i = 0; i < 10; i++) begin
      hold(2'b10, 4, t);
      hold(2'b11, 1, t);
    end
    check("bounce press",  press_n[0] - p0, 0);
    check("bounce update", upd_n - u,       0);
    check("bounce mode",   int'(o_mode),    1);
    hold(2'b10, 10, t);
    check("bounce clean press", press_n[0] - p0, 1);
    check("bounce press edge",  press_at[0],     t + 10);
    hold(2'b11, 15, t);
    check("bounce mode after", int'(o_mode), 2);

    // Long press on key1: one long pulse 32 edges after the press
    l1 = long_n[1];
    hold(2'b01, 50, t);
    check("long count",      long_n[1] - l1,           1);
    check("long press edge", press_at[1],              t + 10);
    check("long distance",   long_at[1] - press_at[1], 32);
    check("long mode",       int'(o_mode),             1);
    hold(2'b11, 15, t);
    check("long no repeat", long_n[1] - l1, 1);

    // Reset mid-hold with key0 still pressed across reset release
    hold(2'b10, 30, t);
    check("mid state before", int'(o_key_state), 1);
    check("mid mode before",  int'(o_mode),      2);
    @(posedge core_clk);
    #1;
    rst_n = 1'b0;
    p0 = press_n[0]; r0 = rel_n[0]; l0 = long_n[0]; u = upd_n;
    repeat (3) @(posedge core_clk);
    @(negedge core_clk);
    check("mid rst state",   int'(o_key_state), 0);
    check("mid rst mode",    int'(o_mode),      0);
    check("mid rst pulses",  (press_n[0] - p0) + (rel_n[0] - r0) + (long_n[0] - l0) + (upd_n - u), 0);
    @(posedge core_clk);
    #1;
    rst_n = 1'b1;
    r = cyc;
    repeat (10) @(posedge core_clk);
    @(negedge core_clk);
    #1;
    check("mid repress count", press_n[0] - p0, 1);
    check("mid repress edge",  press_at[0],      r + 10);
    @(posedge core_clk);
    @(negedge core_clk);
    check("mid mode after", int'(o_mode), 1);
    hold(2'b11, 15, t);
    check("mid release edge", rel_at[0], t + 10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
